// File: rtl/layer_pio_pkg.sv
// rtl/layer_pio_pkg.sv - address map and control/status bit positions for the layer input PIO bank
package layer_pio_pkg;

  localparam int CTRL_ADDR    = 0;
  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_OVR = 1;
  localparam int CTRL_AUTO    = 2;
  localparam int STS_VALID    = 0;
  localparam int STS_OVR      = 1;
  localparam int STS_AUTO     = 2;
  localparam int STS_CNT_LSB  = 8;

  function automatic int shadow_addr(input int i);
    return i + 1;
  endfunction

  function automatic int active_addr(input int n_ch, input int i);
    return n_ch + 1 + i;
  endfunction

endpackage

// File: rtl/layer_input_pio_channel.sv
// rtl/layer_input_pio_channel.sv - one shadow/active register pair of the layer input PIO bank
module layer_input_pio_channel #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              commit,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] shadow_q,
  output logic [DATA_W-1:0] active_q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) shadow_q <= wdata;
      // A shadow written on the commit cycle goes straight through to the active value.
      if (commit) active_q <= wr_en ? wdata : shadow_q;
    end
  end

endmodule

// File: rtl/layer_input_pio_bank.sv
// rtl/layer_input_pio_bank.sv - multi-channel staged neuron input registers with atomic commit and valid/ready output
module layer_input_pio_bank
  import layer_pio_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 9,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic              wr;
  logic              ctrl_wr;
  logic              commit;
  logic              handshake;
  logic              overrun;
  logic              auto_mode;
  logic [7:0]        commit_cnt;
  logic [N_CH-1:0]   wr_en;
  logic [DATA_W-1:0] shadow_q [N_CH];
  logic [DATA_W-1:0] active_q [N_CH];
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr        = chipselect && !write_n;
  assign ctrl_wr   = wr && (address == ADDR_W'(CTRL_ADDR));
  assign handshake = out_valid && out_ready;
  // Auto mode commits on the write to the last channel so a full vector update needs no CTRL write.
  assign commit    = (ctrl_wr && writedata[CTRL_COMMIT]) ||
                     (auto_mode && wr && (address == ADDR_W'(shadow_addr(N_CH - 1))));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_en[i] = wr && (address == ADDR_W'(shadow_addr(i)));

    layer_input_pio_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en[i]),
      .commit   (commit),
      .wdata    (writedata[DATA_W-1:0]),
      .shadow_q (shadow_q[i]),
      .active_q (active_q[i])
    );

    assign out_port[i*DATA_W +: DATA_W] = active_q[i];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      auto_mode  <= 1'b0;
      commit_cnt <= '0;
    end else begin
      if (commit) begin
        out_valid  <= 1'b1;
        commit_cnt <= commit_cnt + 8'd1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      // Setting has priority over a CLR_OVR in the same cycle.
      if (commit && out_valid && !out_ready) overrun <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_CLR_OVR]) overrun <= 1'b0;

      if (ctrl_wr) auto_mode <= writedata[CTRL_AUTO];
    end
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(CTRL_ADDR)) begin
      readdata[STS_VALID]              = out_valid;
      readdata[STS_OVR]                = overrun;
      readdata[STS_AUTO]               = auto_mode;
      readdata[STS_CNT_LSB +: 8]       = commit_cnt;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (address == ADDR_W'(shadow_addr(i)))       readdata[DATA_W-1:0] = shadow_q[i];
      if (address == ADDR_W'(active_addr(N_CH, i))) readdata[DATA_W-1:0] = active_q[i];
    end
  end

endmodule

// File: tb/tb_layer_input_pio_bank.sv
// tb/tb_layer_input_pio_bank.sv - self-checking bench for layer_input_pio_bank
module tb_layer_input_pio_bank;

  logic        clk;
  logic        reset_n;
  logic [5:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [35:0] out_port;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  layer_input_pio_bank #(
    .N_CH   (4),
    .DATA_W (9),
    .ADDR_W (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] exp_rd;
    logic [35:0] exp_port;
    logic        exp_v;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [35:0] pk(input logic [8:0] c0, input logic [8:0] c1,
                                     input logic [8:0] c2, input logic [8:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic void add(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                              input logic rdy, input logic [31:0] exp_rd,
                              input logic [35:0] exp_port, input logic exp_v);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
    v.exp_rd = exp_rd; v.exp_port = exp_port; v.exp_v = exp_v;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                      input logic rdy);
    @(negedge clk);
    chipselect = wr;
    write_n    = !wr;
    address    = addr;
    writedata  = wdata;
    out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [35:0] p_a, p_b, p_c, p_d, p_e;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = '0;
    writedata = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    p_a = pk(9'h1FF, 9'h0A5, 9'h1FF, 9'h001);
    p_b = pk(9'h011, 9'h0A5, 9'h1FF, 9'h001);
    p_c = pk(9'h022, 9'h0A5, 9'h1FF, 9'h001);
    p_d = pk(9'h101, 9'h102, 9'h103, 9'h07F);
    p_e = pk(9'h0AA, 9'h102, 9'h103, 9'h07F);

    // reset state across the whole map and unmapped addresses
    for (int a = 0; a <= 9; a++) add(0, 6'(a), 0, 0, 0, 0, 0);
    add(0, 6'd63, 0, 0, 0, 0, 0);
    // staged writes, truncation, commit
    add(1, 6'd1, 32'h1FF, 0, 32'h1FF, 0, 0);
    add(1, 6'd2, 32'h0A5, 0, 32'h0A5, 0, 0);
    add(1, 6'd3, 32'hFFFF_F3FF, 0, 32'h1FF, 0, 0);
    add(1, 6'd4, 32'h001, 0, 32'h001, 0, 0);
    add(0, 6'd5, 0, 0, 0, 0, 0);
    add(1, 6'd0, 32'h1, 0, 32'h0101, p_a, 1);
    add(0, 6'd5, 0, 0, 32'h1FF, p_a, 1);
    add(0, 6'd6, 0, 0, 32'h0A5, p_a, 1);
    add(0, 6'd7, 0, 0, 32'h1FF, p_a, 1);
    add(0, 6'd8, 0, 0, 32'h001, p_a, 1);
    add(1, 6'd8, 32'h155, 0, 32'h001, p_a, 1);
    add(0, 6'd0, 0, 1, 32'h0100, p_a, 0);
    // two unconsumed commits -> overrun, latest data wins, then CLR_OVR
    add(1, 6'd1, 32'h011, 0, 32'h011, p_a, 0);
    add(1, 6'd0, 32'h1, 0, 32'h0201, p_b, 1);
    add(1, 6'd1, 32'h022, 0, 32'h022, p_b, 1);
    add(1, 6'd0, 32'h1, 0, 32'h0303, p_c, 1);
    add(1, 6'd0, 32'h2, 0, 32'h0301, p_c, 1);
    add(0, 6'd0, 0, 1, 32'h0300, p_c, 0);
    // AUTO mode: only the last channel write commits
    add(1, 6'd0, 32'h4, 0, 32'h0304, p_c, 0);
    add(1, 6'd1, 32'h101, 0, 32'h101, p_c, 0);
    add(1, 6'd2, 32'h102, 0, 32'h102, p_c, 0);
    add(1, 6'd3, 32'h103, 0, 32'h103, p_c, 0);
    add(1, 6'd4, 32'h07F, 0, 32'h07F, p_d, 1);
    add(0, 6'd8, 0, 0, 32'h07F, p_d, 1);
    add(0, 6'd0, 0, 0, 32'h0405, p_d, 1);
    // commit coinciding with handshake: no overrun, stays valid
    add(1, 6'd1, 32'h0AA, 0, 32'h0AA, p_d, 1);
    add(1, 6'd0, 32'h5, 1, 32'h0505, p_e, 1);
    // COMMIT|CLR_OVR with an overrun condition: set wins, then clear
    add(1, 6'd0, 32'h7, 0, 32'h0607, p_e, 1);
    add(1, 6'd0, 32'h6, 0, 32'h0605, p_e, 1);

    foreach (tbl[k]) begin
      step(tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].rdy);
      chk($sformatf("v%0d_readdata", k), 64'(readdata), 64'(tbl[k].exp_rd));
      chk($sformatf("v%0d_out_port", k), 64'(out_port), 64'(tbl[k].exp_port));
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].exp_v));
    end

    // counter wrap: 6 commits so far, 250 more reach 256 -> 0
    for (int n = 0; n < 250; n++) step(1, 6'd0, 32'h5, 1);
    step(0, 6'd0, 0, 0);
    chk("cnt_wrap_status", 64'(readdata), 64'h0005);
    chk("cnt_wrap_port", 64'(out_port), 64'(p_e));

    // reset while a vector is pending
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 6'd0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_port", 64'(out_port), 64'h0);
    chk("rst_status", 64'(readdata), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a <= 8; a++) begin
      step(0, 6'(a), 0, 0);
      chk($sformatf("rst_read_a%0d", a), 64'(readdata), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
